// File: rtl/ram_1w1r_sync.sv
// Single-write, single-read synchronous RAM with per-lane write enables and a post-reset clear sweep.
// Optional macro RAM_1W1R_BYPASS_EN: same-address read/write returns the merged (new) word.
module ram_1w1r_sync #(
  parameter int WORDLENGTH = 32,
  parameter int LOG2_DEPTH = 4,
  parameter int LANE_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [LOG2_DEPTH-1:0]                IN_WADR,
  input  logic                                 IN_WEN,
  input  logic [WORDLENGTH/LANE_WIDTH-1:0]     IN_WBE,
  input  logic [WORDLENGTH-1:0]                IN_WDAT,
  input  logic [LOG2_DEPTH-1:0]                OUT_RADR,
  input  logic                                 OUT_REN,
  output logic [WORDLENGTH-1:0]                OUT_RDAT,
  output logic                                 OUT_RVALID,
  output logic                                 INIT_BUSY
);

  localparam int NLANES = WORDLENGTH / LANE_WIDTH;
  localparam int DEPTH  = 1 << LOG2_DEPTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, state_nxt;
  logic [LOG2_DEPTH-1:0]   cnt, cnt_nxt;
  logic [WORDLENGTH-1:0]   dbuf [DEPTH];
  logic [WORDLENGTH-1:0]   rd_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == '1)
        state_nxt = READY;
    end
  end

  assign INIT_BUSY = (state == CLEAR);

  // Storage has no reset of its own; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        dbuf[cnt] <= '0;
      end else if (IN_WEN) begin
        for (int unsigned i = 0; i < NLANES; i++) begin
          if (IN_WBE[i])
            dbuf[IN_WADR][i*LANE_WIDTH +: LANE_WIDTH] <= IN_WDAT[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

`ifdef RAM_1W1R_BYPASS_EN
  always_comb begin
    rd_word = dbuf[OUT_RADR];
    if (IN_WEN && (IN_WADR == OUT_RADR)) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (IN_WBE[i])
          rd_word[i*LANE_WIDTH +: LANE_WIDTH] = IN_WDAT[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end
`else
  // Array read sees the pre-edge contents, so a colliding read returns the old word.
  assign rd_word = dbuf[OUT_RADR];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      OUT_RDAT   <= '0;
      OUT_RVALID <= 1'b0;
    end else if ((state == READY) && OUT_REN) begin
      OUT_RDAT   <= rd_word;
      OUT_RVALID <= 1'b1;
    end else begin
      OUT_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_1w1r_sync.sv
// Directed self-checking bench for ram_1w1r_sync (default parameters); honours RAM_1W1R_BYPASS_EN.
module tb_ram_1w1r_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  IN_WADR;
  logic        IN_WEN;
  logic [3:0]  IN_WBE;
  logic [31:0] IN_WDAT;
  logic [3:0]  OUT_RADR;
  logic        OUT_REN;
  logic [31:0] OUT_RDAT;
  logic        OUT_RVALID;
  logic        INIT_BUSY;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_1w1r_sync #(.WORDLENGTH(32), .LOG2_DEPTH(4), .LANE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IN_WADR(IN_WADR), .IN_WEN(IN_WEN), .IN_WBE(IN_WBE), .IN_WDAT(IN_WDAT),
    .OUT_RADR(OUT_RADR), .OUT_REN(OUT_REN), .OUT_RDAT(OUT_RDAT),
    .OUT_RVALID(OUT_RVALID), .INIT_BUSY(INIT_BUSY)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IN_WEN  = 1'b0;
    IN_WBE  = 4'b0000;
    IN_WADR = 4'd0;
    IN_WDAT = 32'h0;
    OUT_REN = 1'b0;
    OUT_RADR = 4'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    IN_WEN = 1'b1; IN_WADR = a; IN_WBE = be; IN_WDAT = d;
    step();
    IN_WEN = 1'b0; IN_WBE = 4'b0000;
  endtask

  // Counts cycles until INIT_BUSY falls, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (INIT_BUSY === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (INIT_BUSY !== 1'b1 || OUT_RVALID !== 1'b0 || OUT_RDAT !== 32'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b rvalid=%b rdat=%h required 1 0 00000000", INIT_BUSY, OUT_RVALID, OUT_RDAT);
    end
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL init_busy_len got %0d cycles required 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      OUT_REN = 1'b1; OUT_RADR = 4'(i);
      step();
      checks++;
      if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'h0) begin
        errors++;
        $display("FAIL sweep_read[%0d] rvalid=%b rdat=%h required 1 00000000", i, OUT_RVALID, OUT_RDAT);
      end
    end
    OUT_REN = 1'b0;
    step();
    checks++;
    if (OUT_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_drop got %b required 0", OUT_RVALID);
    end
  endtask

  task automatic test_partial_write();
    wr(4'd3, 4'b1111, 32'hDEADBEEF);
    wr(4'd3, 4'b0010, 32'h00001200);
    wr(4'd3, 4'b0000, 32'h00000000);
    OUT_REN = 1'b1; OUT_RADR = 4'd3;
    step();
    OUT_REN = 1'b0;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'hDEAD12EF) begin
      errors++;
      $display("FAIL partial_write rvalid=%b rdat=%h required 1 dead12ef", OUT_RVALID, OUT_RDAT);
    end
    step();
    checks++;
    if (OUT_RVALID !== 1'b0 || OUT_RDAT !== 32'hDEAD12EF) begin
      errors++;
      $display("FAIL read_hold rvalid=%b rdat=%h required 0 dead12ef", OUT_RVALID, OUT_RDAT);
    end
  endtask

  task automatic test_clear_ignore();
    int n;
    int bad;
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    IN_WEN = 1'b1; IN_WADR = 4'd5; IN_WBE = 4'b1111; IN_WDAT = 32'hFFFFFFFF;
    OUT_REN = 1'b1; OUT_RADR = 4'd5;
    n = 0; bad = 0;
    while (INIT_BUSY === 1'b1 && n < 100) begin
      step();
      n++;
      if (OUT_RVALID !== 1'b0 || OUT_RDAT !== 32'h0) bad++;
    end
    idle();
    checks++;
    if (bad != 0 || n != 16) begin
      errors++;
      $display("FAIL clear_ignore bad_cycles=%0d busy=%0d required 0 16", bad, n);
    end
    OUT_REN = 1'b1; OUT_RADR = 4'd5;
    step();
    OUT_RADR = 4'd3;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'h0) begin
      errors++;
      $display("FAIL clear_addr5 rvalid=%b rdat=%h required 1 00000000", OUT_RVALID, OUT_RDAT);
    end
    step();
    OUT_REN = 1'b0;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'h0) begin
      errors++;
      $display("FAIL clear_addr3 rvalid=%b rdat=%h required 1 00000000", OUT_RVALID, OUT_RDAT);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_first;
`ifdef RAM_1W1R_BYPASS_EN
    exp_first = 32'h11111122;
`else
    exp_first = 32'h11111111;
`endif
    wr(4'd7, 4'b1111, 32'h11111111);
    IN_WEN = 1'b1; IN_WADR = 4'd7; IN_WBE = 4'b0001; IN_WDAT = 32'h22222222;
    OUT_REN = 1'b1; OUT_RADR = 4'd7;
    step();
    IN_WEN = 1'b0; IN_WBE = 4'b0000;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== exp_first) begin
      errors++;
      $display("FAIL collision rvalid=%b rdat=%h required 1 %h", OUT_RVALID, OUT_RDAT, exp_first);
    end
    step();
    OUT_REN = 1'b0;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'h11111122) begin
      errors++;
      $display("FAIL collision_after rvalid=%b rdat=%h required 1 11111122", OUT_RVALID, OUT_RDAT);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp[0] = 32'hA; exp[1] = 32'hB; exp[2] = 32'hC;
    for (int i = 0; i < 3; i++) wr(4'(i), 4'b1111, exp[i]);
    for (int i = 0; i < 3; i++) begin
      OUT_REN = 1'b1; OUT_RADR = 4'(i);
      step();
      checks++;
      if (OUT_RVALID !== 1'b1 || OUT_RDAT !== exp[i]) begin
        errors++;
        $display("FAIL b2b[%0d] rvalid=%b rdat=%h required 1 %h", i, OUT_RVALID, OUT_RDAT, exp[i]);
      end
    end
    // Independent write/read to different addresses in one cycle.
    IN_WEN = 1'b1; IN_WADR = 4'd4; IN_WBE = 4'b1111; IN_WDAT = 32'h00000044;
    OUT_RADR = 4'd1;
    step();
    IN_WEN = 1'b0; IN_WBE = 4'b0000;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'hB) begin
      errors++;
      $display("FAIL rw_diff_read rvalid=%b rdat=%h required 1 0000000b", OUT_RVALID, OUT_RDAT);
    end
    OUT_RADR = 4'd4;
    step();
    OUT_REN = 1'b0;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'h44) begin
      errors++;
      $display("FAIL rw_diff_write rvalid=%b rdat=%h required 1 00000044", OUT_RVALID, OUT_RDAT);
    end
  endtask

  task automatic test_reset_in_ready();
    int n;
    OUT_REN = 1'b1; OUT_RADR = 4'd1;
    rst_n = 1'b0;
    step();
    OUT_REN = 1'b0;
    checks++;
    if (OUT_RVALID !== 1'b0 || OUT_RDAT !== 32'h0 || INIT_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready rvalid=%b rdat=%h busy=%b required 0 00000000 1", OUT_RVALID, OUT_RDAT, INIT_BUSY);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (INIT_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy got %b required 1", INIT_BUSY);
    end
    wait_ready(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL mid_reset_restart got %0d cycles required 16", n);
    end
    OUT_REN = 1'b1; OUT_RADR = 4'd2;
    step();
    OUT_REN = 1'b0;
    checks++;
    if (OUT_RVALID !== 1'b1 || OUT_RDAT !== 32'h0) begin
      errors++;
      $display("FAIL post_restart_read rvalid=%b rdat=%h required 1 00000000", OUT_RVALID, OUT_RDAT);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_partial_write();
    test_clear_ignore();
    test_collision();
    test_back_to_back();
    test_reset_in_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_1w1r_sync.md
RAM_1W1R_SYNC -- requirements
Module: ram_1w1r_sync

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 32: data word width in bits.
REQ-002 SHALL have parameter LOG2_DEPTH, default 4: address width; storage holds 2^LOG2_DEPTH words.
REQ-003 SHALL have parameter LANE_WIDTH, default 8: write-enable lane width; WORDLENGTH SHALL be an integer multiple of it, giving NLANES = WORDLENGTH/LANE_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port IN_WADR  input  LOG2_DEPTH  write address.
REQ-007 SHALL have port IN_WEN  input  1  write enable.
REQ-008 SHALL have port IN_WBE  input  NLANES  per-lane write enable; bit i covers IN_WDAT[i*LANE_WIDTH +: LANE_WIDTH].
REQ-009 SHALL have port IN_WDAT  input  WORDLENGTH  write data.
REQ-010 SHALL have port OUT_RADR  input  LOG2_DEPTH  read address.
REQ-011 SHALL have port OUT_REN  input  1  read enable.
REQ-012 SHALL have port OUT_RDAT  output  WORDLENGTH  registered read data.
REQ-013 SHALL have port OUT_RVALID  output  1  high for exactly one cycle when OUT_RDAT carries data from an accepted read.
REQ-014 SHALL have port INIT_BUSY  output  1  high while the post-reset clear sweep is running.

Function
REQ-015 SHALL implement a two-state controller: CLEAR and READY.
REQ-016 In CLEAR, SHALL write all-zero to entry cnt on each edge and increment cnt; the edge that writes entry 2^LOG2_DEPTH-1 SHALL move the controller to READY.
REQ-017 In CLEAR, SHALL ignore IN_WEN and OUT_REN; OUT_RVALID SHALL remain 0 and OUT_RDAT SHALL hold its value.
REQ-018 INIT_BUSY SHALL be 1 in CLEAR and 0 in READY; after rst_n rises it SHALL stay high for exactly 2^LOG2_DEPTH cycles.
REQ-019 In READY, when IN_WEN=1 at an edge, SHALL update only the lanes of dbuf[IN_WADR] whose IN_WBE bit is 1; the other lanes SHALL be unchanged.
REQ-020 IN_WEN=1 with IN_WBE all zero SHALL leave storage unchanged.
REQ-021 In READY, when OUT_REN=1 at edge N, OUT_RDAT SHALL present dbuf[OUT_RADR] after edge N, and OUT_RVALID SHALL be 1 for that cycle only: one-cycle latency.
REQ-022 When OUT_REN=0, OUT_RDAT SHALL hold its previous value and OUT_RVALID SHALL be 0.
REQ-023 Back-to-back reads, one per cycle, SHALL be supported with OUT_RVALID high continuously.
REQ-024 Read and write to different addresses in the same cycle SHALL both complete independently.
REQ-025 Read and write to the same address in the same cycle SHALL follow REQ-030/REQ-031.
REQ-026 Addresses SHALL be used modulo 2^LOG2_DEPTH; no out-of-range condition exists.

Reset
REQ-027 While rst_n=0 at an edge, SHALL set state=CLEAR, cnt=0, OUT_RDAT=0, OUT_RVALID=0, INIT_BUSY=1; no storage write occurs on that edge.
REQ-028 rst_n asserted mid-CLEAR SHALL restart the sweep from entry 0; asserted in READY it SHALL discard any read in flight, so OUT_RVALID=0 on the next cycle.
REQ-029 Storage contents SHALL be defined only after the sweep completes; no other array reset is required.

Configuration
REQ-030 With macro RAM_1W1R_BYPASS_EN defined, a same-address read and write in one READY cycle SHALL return the merged word: new data on enabled lanes, old data elsewhere.
REQ-031 Without RAM_1W1R_BYPASS_EN, the same collision SHALL return the pre-write (old) word; the write still completes.

Verification
REQ-032 Reset release -> INIT_BUSY=1 for exactly 16 cycles, then 0; reading entries 0..15 returns 0x00000000 each with OUT_RVALID pulses.
REQ-033 Write 0xDEADBEEF to addr 3 with WBE=4'b1111, then WBE=4'b0010 with WDAT=0x00001200 -> read addr 3 returns 0xDEAD12EF one cycle after OUT_REN.
REQ-034 During CLEAR, drive IN_WEN=1 at addr 5 with data 0xFFFFFFFF and OUT_REN=1 -> OUT_RVALID stays 0; after READY, addr 5 reads 0x00000000.
REQ-035 Addr 7 holds 0x11111111; write 0x22222222 to addr 7 with WBE=4'b0001 and read addr 7 in the same cycle -> 0x11111122 with RAM_1W1R_BYPASS_EN, 0x11111111 without; the next read returns 0x11111122 in both builds.
REQ-036 Assert rst_n=0 for one cycle when cnt=9 -> sweep restarts at 0 and INIT_BUSY stays high for a further 16 cycles.
REQ-037 Reads of addrs 0,1,2 in consecutive cycles after writes 0xA,0xB,0xC -> OUT_RVALID high for 3 cycles with OUT_RDAT 0xA, 0xB, 0xC in order.
